// File: rtl/spell_shared_ram_if.sv
// -----------------------------------------------------------------------------
// spell_shared_ram_if
//
// Bundles the two Wishbone ports that reach the shared RAM:
//   - spell RAM-bus port (rambus_wb_*): word-addressed, driven by the spell core
//   - host port (i_wb_* / o_wb_*): byte-addressed, driven by the management CPU
//
// Modports:
//   master : the side that issues requests on both ports (core/host, or a bench)
//   slave  : the shared RAM itself
// -----------------------------------------------------------------------------
interface spell_shared_ram_if #(
    parameter int ADDR_WIDTH = 8
);
    // Spell port
    logic                  rambus_wb_stb_i;
    logic                  rambus_wb_cyc_i;
    logic                  rambus_wb_we_i;
    logic [3:0]            rambus_wb_sel_i;
    logic [31:0]           rambus_wb_dat_i;
    logic [ADDR_WIDTH-1:0] rambus_wb_addr_i;
    logic                  rambus_wb_ack_o;
    logic [31:0]           rambus_wb_dat_o;

    // Host port
    logic                  i_wb_cyc;
    logic                  i_wb_stb;
    logic                  i_wb_we;
    logic [3:0]            i_wb_sel;
    logic [31:0]           i_wb_addr;
    logic [31:0]           i_wb_data;
    logic                  o_wb_ack;
    logic [31:0]           o_wb_data;

    modport master (
        output rambus_wb_stb_i, rambus_wb_cyc_i, rambus_wb_we_i,
               rambus_wb_sel_i, rambus_wb_dat_i, rambus_wb_addr_i,
        input  rambus_wb_ack_o, rambus_wb_dat_o,
        output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_sel, i_wb_addr, i_wb_data,
        input  o_wb_ack, o_wb_data
    );

    modport slave (
        input  rambus_wb_stb_i, rambus_wb_cyc_i, rambus_wb_we_i,
               rambus_wb_sel_i, rambus_wb_dat_i, rambus_wb_addr_i,
        output rambus_wb_ack_o, rambus_wb_dat_o,
        input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_sel, i_wb_addr, i_wb_data,
        output o_wb_ack, o_wb_data
    );
endinterface

// File: rtl/spell_shared_ram.sv
// -----------------------------------------------------------------------------
// spell_shared_ram
//
// Shared 32-bit word memory serving the spell core's RAM bus (port A) and the
// host Wishbone bus (port B). One access per clock reaches the array, chosen
// by a round-robin arbiter; the granted port is acked one cycle later.
//
// Ports:
//   clock : rising-edge system clock
//   reset : synchronous, active-high reset
//   bus   : spell_shared_ram_if.slave carrying both Wishbone ports
//
// Parameters:
//   ADDR_WIDTH : word address width; the array holds 2**ADDR_WIDTH words
// -----------------------------------------------------------------------------
module spell_shared_ram #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic               clock,
    input  logic               reset,
    spell_shared_ram_if.slave  bus
);

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [31:0] mem [0:DEPTH-1];

    port_e       last_grant_q, last_grant_d;
    logic        ack_a_q, ack_a_d;
    logic        ack_b_q, ack_b_d;
    logic [31:0] dat_a_q, dat_a_d;
    logic [31:0] dat_b_q, dat_b_d;

    logic                  elig_a, elig_b;
    logic                  grant_a, grant_b;
    logic [ADDR_WIDTH-1:0] host_word;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic                  acc_we;
    logic [3:0]            acc_sel;
    logic [31:0]           acc_wdata;
    logic                  mem_we;
    logic [31:0]           rd_word;

    // Host address is a byte address; only the word-select bits matter.
    assign host_word = bus.i_wb_addr[ADDR_WIDTH+1:2];

    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.i_wb_addr[31:ADDR_WIDTH+2], bus.i_wb_addr[1:0]};

    // -------------------------------------------------------------------------
    // Arbitration and access selection
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned,
        // which would otherwise infer a latch.
        last_grant_d = last_grant_q;
        ack_a_d      = 1'b0;
        ack_b_d      = 1'b0;
        dat_a_d      = dat_a_q;
        dat_b_d      = dat_b_q;

        // A port in its ack cycle is not eligible, so it cannot be re-granted
        // on the strobe it is about to drop.
        elig_a = bus.rambus_wb_stb_i && bus.rambus_wb_cyc_i && !ack_a_q;
        elig_b = bus.i_wb_stb && bus.i_wb_cyc && !ack_b_q;

        // On a tie the port that did not win last time goes first.
        grant_a = !reset && elig_a && (!elig_b || last_grant_q == PORT_B);
        grant_b = !reset && elig_b && !grant_a;

        acc_addr  = grant_a ? bus.rambus_wb_addr_i : host_word;
        acc_we    = grant_a ? bus.rambus_wb_we_i   : bus.i_wb_we;
        acc_sel   = grant_a ? bus.rambus_wb_sel_i  : bus.i_wb_sel;
        acc_wdata = grant_a ? bus.rambus_wb_dat_i  : bus.i_wb_data;
        mem_we    = (grant_a || grant_b) && acc_we;
        rd_word   = mem[acc_addr];

        if (grant_a) begin
            last_grant_d = PORT_A;
            ack_a_d      = 1'b1;
            if (!acc_we) begin
                dat_a_d = rd_word;
            end
        end else if (grant_b) begin
            last_grant_d = PORT_B;
            ack_b_d      = 1'b1;
            if (!acc_we) begin
                dat_b_d = rd_word;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Control and output registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // values from before the edge, independent of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant_q <= PORT_B;
            ack_a_q      <= 1'b0;
            ack_b_q      <= 1'b0;
            dat_a_q      <= '0;
            dat_b_q      <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            ack_a_q      <= ack_a_d;
            ack_b_q      <= ack_b_d;
            dat_a_q      <= dat_a_d;
            dat_b_q      <= dat_b_d;
        end
    end

    // -------------------------------------------------------------------------
    // Storage array
    // -------------------------------------------------------------------------
    // NOTE: the array has no reset; its contents must survive reset, and a
    // resettable array could not map onto RAM macros.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_sel[i]) begin
                    mem[acc_addr][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

    // An ack registered just before reset rose is dropped rather than
    // reported for an access the master will restart.
    assign bus.rambus_wb_ack_o = ack_a_q && !reset;
    assign bus.o_wb_ack        = ack_b_q && !reset;
    assign bus.rambus_wb_dat_o = dat_a_q;
    assign bus.o_wb_data       = dat_b_q;

endmodule

// File: tb/tb_spell_shared_ram.sv
// -----------------------------------------------------------------------------
// tb_spell_shared_ram
//
// Self-checking bench for spell_shared_ram. Expected responses are queued per
// port when an access is issued and compared when that port acks.
// -----------------------------------------------------------------------------
module tb_spell_shared_ram;

    localparam int AW     = 8;
    localparam int BUDGET = 20;

    typedef struct {
        logic        is_read;
        logic [31:0] data;
    } exp_t;

    logic clk;
    logic reset;

    spell_shared_ram_if #(.ADDR_WIDTH(AW)) bus();

    spell_shared_ram #(.ADDR_WIDTH(AW)) dut (
        .clock (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    exp_t        q_a[$];
    exp_t        q_b[$];
    logic [31:0] model [0:(1<<AW)-1];
    logic [31:0] last_read_a = 32'h0;
    logic [31:0] last_read_b = 32'h0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [3:0] sel,
                                          input logic [31:0] dat);
        logic [31:0] w;
        w = old_w;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) w[8*i +: 8] = dat[8*i +: 8];
        end
        return w;
    endfunction

    // -------------------------------------------------------------------------
    // Response monitors
    // -------------------------------------------------------------------------
    always @(negedge clk) begin
        exp_t e;
        if (bus.rambus_wb_ack_o) begin
            if (q_a.size() == 0) begin
                check("a_unexpected_ack", 32'd1, 32'd0);
            end else begin
                e = q_a.pop_front();
                if (e.is_read) begin
                    check("a_read_data", bus.rambus_wb_dat_o, e.data);
                    last_read_a = e.data;
                end else begin
                    check("a_write_hold", bus.rambus_wb_dat_o, last_read_a);
                end
            end
        end
        if (bus.o_wb_ack) begin
            if (q_b.size() == 0) begin
                check("b_unexpected_ack", 32'd1, 32'd0);
            end else begin
                e = q_b.pop_front();
                if (e.is_read) begin
                    check("b_read_data", bus.o_wb_data, e.data);
                    last_read_b = e.data;
                end else begin
                    check("b_write_hold", bus.o_wb_data, last_read_b);
                end
            end
        end
        if (bus.rambus_wb_ack_o || bus.o_wb_ack) begin
            check("single_ack", {31'b0, bus.rambus_wb_ack_o & bus.o_wb_ack}, 32'd0);
        end
    end

    // -------------------------------------------------------------------------
    // Port drivers (one uncontended access each, 1-cycle latency expected)
    // -------------------------------------------------------------------------
    task automatic a_access(input logic we, input logic [AW-1:0] addr,
                            input logic [3:0] sel, input logic [31:0] dat);
        exp_t e;
        int   n;
        e.is_read = !we;
        e.data    = we ? 32'h0 : model[addr];
        if (we) model[addr] = merge(model[addr], sel, dat);
        q_a.push_back(e);
        @(posedge clk);
        #1;
        bus.rambus_wb_we_i   = we;
        bus.rambus_wb_addr_i = addr;
        bus.rambus_wb_sel_i  = sel;
        bus.rambus_wb_dat_i  = dat;
        bus.rambus_wb_stb_i  = 1'b1;
        bus.rambus_wb_cyc_i  = 1'b1;
        for (n = 0; n < BUDGET; n++) begin
            @(negedge clk);
            if (bus.rambus_wb_ack_o) break;
        end
        if (n == BUDGET) check("a_timeout", 32'd0, 32'd1);
        else             check("a_latency", n, 32'd1);
        bus.rambus_wb_stb_i = 1'b0;
        bus.rambus_wb_cyc_i = 1'b0;
    endtask

    task automatic b_access(input logic we, input logic [31:0] byte_addr,
                            input logic [3:0] sel, input logic [31:0] dat);
        exp_t          e;
        int            n;
        logic [AW-1:0] w;
        w         = byte_addr[AW+1:2];
        e.is_read = !we;
        e.data    = we ? 32'h0 : model[w];
        if (we) model[w] = merge(model[w], sel, dat);
        q_b.push_back(e);
        @(posedge clk);
        #1;
        bus.i_wb_we   = we;
        bus.i_wb_addr = byte_addr;
        bus.i_wb_sel  = sel;
        bus.i_wb_data = dat;
        bus.i_wb_stb  = 1'b1;
        bus.i_wb_cyc  = 1'b1;
        for (n = 0; n < BUDGET; n++) begin
            @(negedge clk);
            if (bus.o_wb_ack) break;
        end
        if (n == BUDGET) check("b_timeout", 32'd0, 32'd1);
        else             check("b_latency", n, 32'd1);
        bus.i_wb_stb = 1'b0;
        bus.i_wb_cyc = 1'b0;
    endtask

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        reset                = 1'b1;
        bus.rambus_wb_stb_i  = 1'b0;
        bus.rambus_wb_cyc_i  = 1'b0;
        bus.rambus_wb_we_i   = 1'b0;
        bus.rambus_wb_sel_i  = 4'h0;
        bus.rambus_wb_dat_i  = 32'h0;
        bus.rambus_wb_addr_i = '0;
        bus.i_wb_cyc         = 1'b0;
        bus.i_wb_stb         = 1'b0;
        bus.i_wb_we          = 1'b0;
        bus.i_wb_sel         = 4'h0;
        bus.i_wb_addr        = 32'h0;
        bus.i_wb_data        = 32'h0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ack_a", {31'b0, bus.rambus_wb_ack_o}, 32'd0);
        check("rst_ack_b", {31'b0, bus.o_wb_ack}, 32'd0);
        check("rst_dat_a", bus.rambus_wb_dat_o, 32'h0);
        check("rst_dat_b", bus.o_wb_data, 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Spell write then read back.
        a_access(1'b1, 8'h05, 4'hF, 32'hDEADBEEF);
        a_access(1'b0, 8'h05, 4'hF, 32'h0);

        // Byte lanes, including an all-lanes-off no-op write.
        a_access(1'b1, 8'h10, 4'hF, 32'h11223344);
        a_access(1'b1, 8'h10, 4'h2, 32'h0000AA00);
        a_access(1'b0, 8'h10, 4'h0, 32'h0);
        check("lane_merge_model", model[8'h10], 32'h1122AA44);
        a_access(1'b1, 8'h10, 4'h0, 32'hFFFFFFFF);
        a_access(1'b0, 8'h10, 4'hF, 32'h0);

        // Preload a word and give the host a non-zero read value.
        b_access(1'b1, 32'h0000_001C, 4'hF, 32'h0777_7777);
        b_access(1'b0, 32'h0000_001C, 4'hF, 32'h0);

        // Reset held 2 cycles with both ports strobing writes.
        @(posedge clk);
        #1;
        reset                = 1'b1;
        bus.rambus_wb_we_i   = 1'b1;
        bus.rambus_wb_addr_i = 8'h07;
        bus.rambus_wb_sel_i  = 4'hF;
        bus.rambus_wb_dat_i  = 32'hBAD0BAD0;
        bus.rambus_wb_stb_i  = 1'b1;
        bus.rambus_wb_cyc_i  = 1'b1;
        bus.i_wb_we          = 1'b1;
        bus.i_wb_addr        = 32'h0000_001C;
        bus.i_wb_sel         = 4'hF;
        bus.i_wb_data        = 32'hBAD1BAD1;
        bus.i_wb_stb         = 1'b1;
        bus.i_wb_cyc         = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            if (i == 1) begin
                #1;
                reset               = 1'b0;
                bus.rambus_wb_stb_i = 1'b0;
                bus.rambus_wb_cyc_i = 1'b0;
                bus.i_wb_stb        = 1'b0;
                bus.i_wb_cyc        = 1'b0;
            end
            @(negedge clk);
            check("hold_rst_ack_a", {31'b0, bus.rambus_wb_ack_o}, 32'd0);
            check("hold_rst_ack_b", {31'b0, bus.o_wb_ack}, 32'd0);
            check("hold_rst_dat_a", bus.rambus_wb_dat_o, 32'h0);
            check("hold_rst_dat_b", bus.o_wb_data, 32'h0);
        end
        last_read_a = 32'h0;
        last_read_b = 32'h0;
        a_access(1'b0, 8'h07, 4'hF, 32'h0);

        // Cross-port visibility and host address truncation.
        a_access(1'b1, 8'h05, 4'hF, 32'hCAFE0001);
        b_access(1'b0, 32'h3000_0014, 4'hF, 32'h0);
        b_access(1'b1, 32'h0000_0424, 4'hF, 32'h600D_F00D);
        a_access(1'b0, 8'h09, 4'hF, 32'h0);
        b_access(1'b1, 32'h0000_0400, 4'hF, 32'h5A5A0F0F);
        a_access(1'b0, 8'h00, 4'hF, 32'h0);

        // Preload tie-test words, then abort a read with reset.
        a_access(1'b1, 8'h20, 4'hF, 32'h12345678);
        a_access(1'b1, 8'h40, 4'hF, 32'hA0A0A0A0);
        b_access(1'b1, 32'h0000_0104, 4'hF, 32'hB1B1B1B1);
        @(posedge clk);
        #1;
        bus.rambus_wb_we_i   = 1'b0;
        bus.rambus_wb_addr_i = 8'h20;
        bus.rambus_wb_stb_i  = 1'b1;
        bus.rambus_wb_cyc_i  = 1'b1;
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("abort_ack_a", {31'b0, bus.rambus_wb_ack_o}, 32'd0);
        @(posedge clk);
        #1;
        reset               = 1'b0;
        bus.rambus_wb_stb_i = 1'b0;
        bus.rambus_wb_cyc_i = 1'b0;
        last_read_a = 32'h0;
        last_read_b = 32'h0;

        // Tie arbitration straight out of reset: A, B, A, B.
        q_a.push_back('{is_read: 1'b1, data: model[8'h40]});
        q_a.push_back('{is_read: 1'b1, data: model[8'h40]});
        q_b.push_back('{is_read: 1'b1, data: model[8'h41]});
        q_b.push_back('{is_read: 1'b1, data: model[8'h41]});
        @(posedge clk);
        #1;
        bus.rambus_wb_we_i   = 1'b0;
        bus.rambus_wb_addr_i = 8'h40;
        bus.rambus_wb_stb_i  = 1'b1;
        bus.rambus_wb_cyc_i  = 1'b1;
        bus.i_wb_we          = 1'b0;
        bus.i_wb_addr        = 32'h0000_0104;
        bus.i_wb_stb         = 1'b1;
        bus.i_wb_cyc         = 1'b1;
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            check($sformatf("tie_ack_a_%0d", k), {31'b0, bus.rambus_wb_ack_o},
                  (k % 2 == 1) ? 32'd1 : 32'd0);
            check($sformatf("tie_ack_b_%0d", k), {31'b0, bus.o_wb_ack},
                  (k != 0 && k % 2 == 0) ? 32'd1 : 32'd0);
            if (k == 3) begin
                bus.rambus_wb_stb_i = 1'b0;
                bus.rambus_wb_cyc_i = 1'b0;
            end
            if (k == 4) begin
                bus.i_wb_stb = 1'b0;
                bus.i_wb_cyc = 1'b0;
            end
        end

        // Write completed before reset is still there.
        a_access(1'b0, 8'h20, 4'hF, 32'h0);
        check("persist_model", model[8'h20], 32'h12345678);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("q_a_drained", q_a.size(), 32'd0);
        check("q_b_drained", q_b.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
